// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the imem request handshake,
// and presents {pc, pc+4, instruction} with a one-cycle IF/ID load strobe.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_load,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic [31:0] instr_out
);

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] pending_pc_r;
  logic [31:0] buf_r;
  logic        deliver_s;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  assign imem_address = pc_r;
  assign pc_out       = pc_r;
  assign pc_plus4_out = next_seq_pc(pc_r);
  assign ifid_load    = deliver_s;

  // Request, delivery strobe and instruction mux decoded from the current state
  always_comb begin
    imem_read = 1'b0;
    deliver_s = 1'b0;
    instr_out = 32'h0000_0000;
    case (state_r)
      FETCH: begin
        imem_read = 1'b1;
        deliver_s = imem_resp && !redirect && !stall;
        instr_out = imem_rdata;
      end
      DROP: begin
        imem_read = 1'b1;
      end
      HOLD: begin
        deliver_s = !redirect && !stall;
        instr_out = buf_r;
      end
      default: begin
        imem_read = 1'b0;
        deliver_s = 1'b0;
        instr_out = 32'h0000_0000;
      end
    endcase
  end

  // Fetch FSM; pc only moves when no request is outstanding so the address stays stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= START;
      pc_r         <= RESET_PC;
      pending_pc_r <= 32'h0000_0000;
      buf_r        <= 32'h0000_0000;
    end else begin
      case (state_r)
        START: begin
          if (redirect) begin
            pc_r <= redirect_pc;
          end
          state_r <= FETCH;
        end
        FETCH: begin
          if (imem_resp) begin
            if (redirect) begin
              pc_r <= redirect_pc;
            end else if (!stall) begin
              pc_r <= next_seq_pc(pc_r);
            end else begin
              buf_r   <= imem_rdata;
              state_r <= HOLD;
            end
          end else if (redirect) begin
            pending_pc_r <= redirect_pc;
            state_r      <= DROP;
          end
        end
        DROP: begin
          if (imem_resp) begin
            pc_r    <= redirect ? redirect_pc : pending_pc_r;
            state_r <= FETCH;
          end else if (redirect) begin
            pending_pc_r <= redirect_pc;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_r    <= redirect_pc;
            state_r <= FETCH;
          end else if (!stall) begin
            pc_r    <= next_seq_pc(pc_r);
            state_r <= FETCH;
          end
        end
        default: begin
          state_r <= START;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against a request/squash/held-word
// reference model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0060;

  logic        clk;
  logic        rst;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_load;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic [31:0] instr_out;

  int checks = 0;
  int errors = 0;
  int loads_seen = 0;

  // reference model: a request flag, a squash flag with its target, and a held-word queue
  logic        m_started;
  logic        m_req;
  logic        m_squash;
  logic [31:0] m_target;
  logic [31:0] m_pc;
  logic [31:0] m_held[$];

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_address (imem_address),
    .imem_read    (imem_read),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .ifid_load    (ifid_load),
    .pc_out       (pc_out),
    .pc_plus4_out (pc_plus4_out),
    .instr_out    (instr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_req     = 1'b0;
    m_squash  = 1'b0;
    m_target  = 32'h0;
    m_pc      = RPC;
    m_held.delete();
  endtask

  // apply inputs for this cycle and compare every output against the model
  task automatic drive(input logic r, input logic [31:0] d, input logic s,
                       input logic rd, input logic [31:0] rp);
    logic        fresh;
    logic        held;
    logic [31:0] e_instr;
    logic        e_load;
    imem_resp   = r;
    imem_rdata  = d;
    stall       = s;
    redirect    = rd;
    redirect_pc = rp;
    #1;
    fresh   = m_req && !m_squash;
    held    = (m_held.size() > 0);
    e_instr = fresh ? imem_rdata : (held ? m_held[0] : 32'h0);
    e_load  = (fresh && imem_resp && !redirect && !stall) || (held && !redirect && !stall);
    chk("imem_read", {31'b0, imem_read}, {31'b0, m_req});
    chk("imem_address", imem_address, m_pc);
    chk("pc_out", pc_out, m_pc);
    chk("pc_plus4_out", pc_plus4_out, m_pc + 32'd4);
    chk("instr_out", instr_out, e_instr);
    chk("ifid_load", {31'b0, ifid_load}, {31'b0, e_load});
    if (e_load) loads_seen++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (!m_started) begin
        m_started = 1'b1;
        m_req     = 1'b1;
        if (redirect) m_pc = redirect_pc;
      end else if (m_held.size() > 0) begin
        if (redirect) begin
          m_pc = redirect_pc;
          m_held.delete();
          m_req = 1'b1;
        end else if (!stall) begin
          m_pc = m_pc + 32'd4;
          m_held.delete();
          m_req = 1'b1;
        end
      end else if (m_squash) begin
        if (imem_resp) begin
          m_pc     = redirect ? redirect_pc : m_target;
          m_squash = 1'b0;
        end else if (redirect) begin
          m_target = redirect_pc;
        end
      end else if (m_req) begin
        if (imem_resp) begin
          if (redirect) m_pc = redirect_pc;
          else if (!stall) m_pc = m_pc + 32'd4;
          else begin
            m_held.push_back(imem_rdata);
            m_req = 1'b0;
          end
        end else if (redirect) begin
          m_squash = 1'b1;
          m_target = redirect_pc;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic        r;
    logic        s;
    logic        rd;
    logic [31:0] rp;
    rst = 1'b1;
    imem_resp = 1'b0; imem_rdata = 32'h0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    model_reset();
    #2;
    chk("rst_read", {31'b0, imem_read}, 32'd0);
    chk("rst_load", {31'b0, ifid_load}, 32'd0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_addr", imem_address, 32'h60);
    chk("rst_plus4", pc_plus4_out, 32'h64);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset release, latency 2
    drive(0, 32'h0, 0, 0, 32'h0); chk("tp_start_noreq", {31'b0, imem_read}, 32'd0); tick();
    drive(0, 32'h0, 0, 0, 32'h0); chk("tp_first_addr", imem_address, 32'h60); tick();
    drive(0, 32'h0, 0, 0, 32'h0); tick();
    drive(1, 32'h0000_0013, 0, 0, 32'h0);
    chk("tp_load0", {31'b0, ifid_load}, 32'd1);
    chk("tp_pc0", pc_out, 32'h60);
    chk("tp_pc4_0", pc_plus4_out, 32'h64);
    tick();
    // stall on response, 3 stalled cycles
    drive(0, 32'h0, 0, 0, 32'h0); chk("tp_next_addr", imem_address, 32'h64); tick();
    drive(0, 32'h0, 0, 0, 32'h0); tick();
    drive(1, 32'h00A0_0093, 1, 0, 32'h0); chk("tp_stall_noload", {31'b0, ifid_load}, 32'd0); tick();
    drive(0, 32'h0, 1, 0, 32'h0); chk("tp_hold_noread", {31'b0, imem_read}, 32'd0); tick();
    drive(0, 32'h0, 1, 0, 32'h0); tick();
    drive(0, 32'h0, 0, 0, 32'h0);
    chk("tp_hold_load", {31'b0, ifid_load}, 32'd1);
    chk("tp_hold_instr", instr_out, 32'h00A0_0093);
    tick();
    // redirect with request outstanding
    drive(0, 32'h0, 0, 1, 32'h200); chk("tp_addr68", imem_address, 32'h68); tick();
    drive(0, 32'h0, 0, 0, 32'h0); chk("tp_drop_addr", imem_address, 32'h68); tick();
    drive(1, 32'hDEAD_BEEF, 0, 0, 32'h0); chk("tp_drop_noload", {31'b0, ifid_load}, 32'd0); tick();
    drive(0, 32'h0, 0, 0, 32'h0); chk("tp_addr200", imem_address, 32'h200); tick();
    // double redirect in DROP
    drive(0, 32'h0, 0, 1, 32'h300); tick();
    drive(0, 32'h0, 0, 1, 32'h400); tick();
    drive(1, 32'h1111_1111, 0, 0, 32'h0); tick();
    drive(0, 32'h0, 0, 0, 32'h0); chk("tp_addr400", imem_address, 32'h400); tick();
    // redirect coincident with response and stall
    drive(1, 32'h2222_2222, 1, 1, 32'h80); chk("tp_coinc_noload", {31'b0, ifid_load}, 32'd0); tick();
    drive(0, 32'h0, 0, 0, 32'h0); chk("tp_addr80", imem_address, 32'h80); tick();
    // wrap
    drive(1, 32'h3333_3333, 0, 1, 32'hFFFF_FFFC); tick();
    drive(1, 32'h1234_5678, 0, 0, 32'h0); chk("tp_wrap", pc_plus4_out, 32'h0); tick();
    // async reset mid-request
    drive(0, 32'h0, 0, 0, 32'h0);
    rst = 1'b1;
    #1;
    chk("tp_async_read", {31'b0, imem_read}, 32'd0);
    chk("tp_async_addr", imem_address, 32'h60);
    model_reset();
    tick();
    rst = 1'b0;
    drive(1, 32'h4444_4444, 0, 0, 32'h0); chk("tp_start_resp_noload", {31'b0, ifid_load}, 32'd0); tick();
    drive(0, 32'h0, 0, 0, 32'h0); chk("tp_restart_addr", imem_address, 32'h60); tick();

    // randomized traffic
    loads_seen = 0;
    for (int i = 0; i < 4000; i++) begin
      r  = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      s  = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 7) == 0);
      rp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      drive(r, $urandom, s, rd, rp);
      if ((i % 700) == 350) begin
        rst = 1'b1;
        #1;
        chk("rand_async_read", {31'b0, imem_read}, 32'd0);
        model_reset();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    chk("rand_loads_seen", {31'b0, (loads_seen > 0)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
